boa_uart_tx_arbiter: RTL and testbench

BOA_UART_TX_ARBITER -- requirements
Module: boa_uart_tx_arbiter

---
 rtl/boa_uart_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_boa_uart_tx_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/boa_uart_tx_arbiter.sv
// rtl/boa_uart_tx_arbiter.sv - round-robin arbiter feeding whole messages to one unbuffered UART transmitter
// Optional grant timeout: define BOA_UART_ARB_TIMEOUT_EN.
module boa_uart_tx_arbiter #(
  parameter int n_req   = 4,
  parameter int timeout = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [n_req-1:0]   req_valid,
  input  logic [8*n_req-1:0] req_byte,
  input  logic [n_req-1:0]   req_last,
  output logic [n_req-1:0]   req_ready,
  output logic [7:0]         phy_byte,
  output logic               phy_trig,
  input  logic               phy_ack,
  output logic [n_req-1:0]   grant,
  output logic               busy
);

  localparam int PW = (n_req > 1) ? $clog2(n_req) : 1;

  if (n_req < 2 || n_req > 8 || timeout < 1 || timeout > 65535) begin : g_bad_params
    $error("boa_uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, OPEN, TRIG, ACKW} state_t;

  state_t           state, state_nx;
  logic [n_req-1:0] grant_r, grant_nx;
  logic [PW-1:0]    rr_ptr, rr_nx;
  logic [7:0]       hold_byte;
  logic             hold_last;
  logic [PW-1:0]    pick;
  logic             pick_ok;
  logic [7:0]       gnt_byte;
  logic             gnt_valid, gnt_last, accept, to_hit;
  int               idx;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    idx     = 0;
    for (int k = 0; k < n_req; k++) begin
      idx = (int'(rr_ptr) + k) % n_req;
      if (!pick_ok && req_valid[idx]) begin
        pick_ok = 1'b1;
        pick    = PW'(idx);
      end
    end
  end

  always_comb begin
    gnt_byte = '0;
    for (int i = 0; i < n_req; i++) begin
      if (grant_r[i]) gnt_byte = gnt_byte | req_byte[8*i +: 8];
    end
  end

  assign gnt_valid = |(req_valid & grant_r);
  assign gnt_last  = |(req_last & grant_r);
  assign accept    = (state == OPEN) && gnt_valid;

`ifdef BOA_UART_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;

  assign to_hit = (state == OPEN) && !gnt_valid && (to_cnt + 16'd1 == 16'(timeout));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state != OPEN || gnt_valid || to_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 16'd1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    grant_nx = grant_r;
    rr_nx    = rr_ptr;
    case (state)
      IDLE: begin
        grant_nx = '0;
        if (pick_ok) begin
          grant_nx = {{(n_req-1){1'b0}}, 1'b1} << pick;
          rr_nx    = (pick == PW'(n_req - 1)) ? '0 : pick + 1'b1;
          state_nx = OPEN;
        end
      end
      OPEN: begin
        if (to_hit) begin
          grant_nx = '0;
          state_nx = IDLE;
        end else if (accept) begin
          state_nx = TRIG;
        end
      end
      TRIG: begin
        if (phy_ack) state_nx = ACKW;
      end
      ACKW: begin
        if (!phy_ack) begin
          if (hold_last) begin
            grant_nx = '0;
            state_nx = IDLE;
          end else begin
            state_nx = OPEN;
          end
        end
      end
      default: begin
        grant_nx = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_r   <= '0;
      rr_ptr    <= '0;
      hold_byte <= '0;
      hold_last <= 1'b0;
    end else begin
      state   <= state_nx;
      grant_r <= grant_nx;
      rr_ptr  <= rr_nx;
      if (accept) begin
        hold_byte <= gnt_byte;
        hold_last <= gnt_last;
      end
    end
  end

  assign req_ready = (state == OPEN) ? grant_r : '0;
  assign grant     = grant_r;
  assign phy_byte  = hold_byte;
  assign phy_trig  = (state == TRIG);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_boa_uart_tx_arbiter.sv
// tb/tb_boa_uart_tx_arbiter.sv - scoreboard bench for boa_uart_tx_arbiter
// Timeout scenario runs only when BOA_UART_ARB_TIMEOUT_EN is defined.
module tb_boa_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_byte;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  phy_byte;
  logic        phy_trig;
  logic        phy_ack;
  logic [3:0]  grant;
  logic        busy;

  boa_uart_tx_arbiter #(.n_req(4), .timeout(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_byte(req_byte),
    .req_last(req_last), .req_ready(req_ready), .phy_byte(phy_byte),
    .phy_trig(phy_trig), .phy_ack(phy_ack), .grant(grant), .busy(busy)
  );

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          trig_cnt = 0;
  int          ack_delay = 1;
  int          ack_hold = 1;
  logic [8:0]  rq [4][$];
  logic [11:0] sbq [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(int r, logic [7:0] b, logic l);
    rq[r].push_back({l, b});
  endtask

  task automatic expect_tx(logic [3:0] g, logic [7:0] b);
    sbq.push_back({g, b});
  endtask

  // Requester models: offer the queue head, pop once it was accepted.
  initial begin
    logic [3:0] acc;
    req_valid = '0;
    req_byte  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_byte[8*i +: 8] = rq[i][0][7:0];
          req_last[i]        = rq[i][0][8];
        end else begin
          req_valid[i]       = 1'b0;
          req_byte[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  // Transmitter model: acknowledge ack_delay cycles after trigger, hold ack_hold cycles.
  initial begin
    phy_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (phy_trig) begin
        repeat (ack_delay) @(posedge clk);
        #1 phy_ack = 1'b1;
        repeat (ack_hold) @(posedge clk);
        #1 phy_ack = 1'b0;
      end
    end
  end

  // Monitor: compare each new trigger against the scoreboard.
  initial begin
    logic        prev_trig;
    logic        pending;
    int          t_req;
    logic [11:0] e;
    prev_trig = 1'b0;
    pending   = 1'b0;
    t_req     = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_trig = 1'b0;
        pending   = 1'b0;
      end else begin
        if (!busy && |req_valid && !pending) begin
          pending = 1'b1;
          t_req   = cyc;
        end
        if (busy) check("grant_onehot", {31'd0, $onehot(grant)}, 32'd1);
        if (phy_trig && !prev_trig) begin
          trig_cnt++;
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_trig: got byte %0h grant %0h expected none", phy_byte, grant);
          end else begin
            e = sbq.pop_front();
            check("tx_grant", {28'd0, grant}, {28'd0, e[11:8]});
            check("tx_byte", {24'd0, phy_byte}, {24'd0, e[7:0]});
          end
          if (pending) begin
            check("latency_le2", {31'd0, (cyc - t_req) <= 2}, 32'd1);
            pending = 1'b0;
          end
        end
        prev_trig = phy_trig;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(string name);
    int n;
    n = 0;
    while ((sbq.size() != 0 || busy || phy_ack || rq[0].size() != 0 || rq[1].size() != 0 ||
            rq[2].size() != 0 || rq[3].size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, n < 400}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_trig(string name);
    int n;
    n = 0;
    while (!phy_trig && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, phy_trig}, 32'd1);
  endtask

  initial begin
    int tc;
    int n;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_grant", {28'd0, grant}, 32'd0);
    check("rst_ready", {28'd0, req_ready}, 32'd0);
    check("rst_trig", {31'd0, phy_trig}, 32'd0);
    check("rst_byte", {24'd0, phy_byte}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    // Single byte from requester 1, slow acknowledge.
    ack_delay = 3;
    push(1, 8'h55, 1'b1);
    expect_tx(4'b0010, 8'h55);
    wait_done("single_done");
    check("single_grant_after", {28'd0, grant}, 32'd0);
    check("single_trig_count", trig_cnt, 1);
    ack_delay = 1;

    // Simultaneous 2-byte messages from requesters 0 and 2: no interleaving.
    do_reset();
    push(0, 8'hAA, 1'b0); push(0, 8'hAB, 1'b1);
    push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b1);
    expect_tx(4'b0001, 8'hAA); expect_tx(4'b0001, 8'hAB);
    expect_tx(4'b0100, 8'hC0); expect_tx(4'b0100, 8'hC1);
    wait_done("pair_done");

    // All four continuously valid: order 0,1,2,3,0.
    do_reset();
    push(0, 8'h10, 1'b1); push(0, 8'h20, 1'b1);
    push(1, 8'h11, 1'b1); push(2, 8'h12, 1'b1); push(3, 8'h13, 1'b1);
    expect_tx(4'b0001, 8'h10); expect_tx(4'b0010, 8'h11);
    expect_tx(4'b0100, 8'h12); expect_tx(4'b1000, 8'h13);
    expect_tx(4'b0001, 8'h20);
    wait_done("rr_done");

    // Long acknowledge: stays in ACKW, no retrigger.
    ack_hold = 5;
    tc = trig_cnt;
    push(1, 8'h5A, 1'b1);
    expect_tx(4'b0010, 8'h5A);
    n = 0;
    while (!phy_ack && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("ackw_no_trig", {31'd0, phy_trig}, 32'd0);
      check("ackw_busy", {31'd0, busy}, 32'd1);
    end
    wait_done("ackhold_done");
    check("ackhold_trig_count", trig_cnt - tc, 1);
    ack_hold = 1;

    // Reset while holding 0xA7 in TRIG.
    ack_delay = 6;
    push(2, 8'hA7, 1'b1);
    expect_tx(4'b0100, 8'hA7);
    wait_trig("a7_trig_seen");
    @(negedge clk);
    tc = trig_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_trig", {31'd0, phy_trig}, 32'd0);
    check("midrst_grant", {28'd0, grant}, 32'd0);
    check("midrst_byte", {24'd0, phy_byte}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_resend", trig_cnt, tc);
    ack_delay = 1;
    push(3, 8'h33, 1'b1); push(2, 8'h32, 1'b1);
    expect_tx(4'b0100, 8'h32); expect_tx(4'b1000, 8'h33);
    wait_done("midrst_restart_done");

`ifdef BOA_UART_ARB_TIMEOUT_EN
    // Requester 3 opens a message then goes silent; timeout releases the grant.
    do_reset();
    push(3, 8'h77, 1'b0);
    expect_tx(4'b1000, 8'h77);
    wait_trig("to_trig_seen");
    push(0, 8'h01, 1'b1);
    expect_tx(4'b0001, 8'h01);
    n = 0;
    while (!req_ready[3] && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (req_ready[3] && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("timeout_open_cycles", n, 8);
    check("timeout_grant_drop", {28'd0, grant}, 32'd0);
    wait_done("timeout_done");
`endif

    check("final_sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
